// File: rtl/pe_bcast_arbiter.sv
// Round-robin scheduler for the PE 1-to-2 broadcast resource: eager fork to out0/out1, recovery gap after each packet.
// Optional feature macro PE_BCAST_INIT_TOKEN_EN: prime both consumers with one all-zero token after reset.
module pe_bcast_arbiter #(
    parameter int  WIDTH   = 4,
    parameter int  NREQ    = 4,
    parameter int  GAP_CYC = 1,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                  out0_valid,
    input  logic                  out0_ready,
    output logic [WIDTH-1:0]      out0_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [IDW-1:0]        out_src,
    output logic                  busy,
    output logic [15:0]           bcast_cnt
);

`ifdef PE_BCAST_INIT_TOKEN_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2, S_INIT = 2'd3} state_t;
    localparam state_t RST_STATE = S_INIT;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;
    localparam state_t RST_STATE = S_IDLE;
`endif
    localparam state_t END_STATE = (GAP_CYC == 0) ? S_IDLE : S_GAP;

    state_t            state_r;
    logic [WIDTH-1:0]  pkt_q_r;
    logic [IDW-1:0]    out_src_r;
    logic [IDW-1:0]    rr_ptr_r;
    logic              done0_r;
    logic              done1_r;
    logic              out0_valid_r;
    logic              out1_valid_r;
    logic [3:0]        gap_cnt_r;
    logic [15:0]       bcast_cnt_r;

    logic              grant_found_s;
    logic [IDW-1:0]    grant_idx_s;
    logic [WIDTH-1:0]  grant_data_s;
    logic              done0_nxt_s;
    logic              done1_nxt_s;
    logic              both_done_s;
    logic [IDW-1:0]    src_inc_s;

    // Round-robin search: lowest offset from rr_ptr with a valid request wins.
    always_comb begin
        logic [IDW:0]   sum_v;
        logic [IDW-1:0] idx_v;
        sum_v         = '0;
        idx_v         = '0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum_v         = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            idx_v         = (sum_v >= (IDW+1)'(NREQ)) ? IDW'(sum_v - (IDW+1)'(NREQ)) : sum_v[IDW-1:0];
            grant_found_s = grant_found_s | req_valid[idx_v];
            grant_idx_s   = req_valid[idx_v] ? idx_v : grant_idx_s;
        end
    end

    assign grant_data_s = req_data[int'(grant_idx_s) * WIDTH +: WIDTH];
    assign done0_nxt_s  = done0_r | (out0_valid_r & out0_ready);
    assign done1_nxt_s  = done1_r | (out1_valid_r & out1_ready);
    assign both_done_s  = done0_nxt_s & done1_nxt_s;
    assign src_inc_s    = (out_src_r == IDW'(NREQ - 1)) ? {IDW{1'b0}} : out_src_r + IDW'(1);

    // The accept strobe must be combinational so the requester sees it in the grant cycle.
    assign req_ready  = (state_r == S_IDLE && grant_found_s) ?
                        ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s) : {NREQ{1'b0}};
    assign out0_valid = out0_valid_r;
    assign out1_valid = out1_valid_r;
    assign out0_data  = pkt_q_r;
    assign out_src    = out_src_r;
    assign busy       = (state_r != S_IDLE);
    assign bcast_cnt  = bcast_cnt_r;

    // Scheduler FSM; output valids are registered and track the per-consumer done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RST_STATE;
            pkt_q_r      <= '0;
            out_src_r    <= '0;
            rr_ptr_r     <= '0;
            done0_r      <= 1'b0;
            done1_r      <= 1'b0;
            out0_valid_r <= 1'b0;
            out1_valid_r <= 1'b0;
            gap_cnt_r    <= 4'd0;
            bcast_cnt_r  <= 16'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (grant_found_s) begin
                        pkt_q_r      <= grant_data_s;
                        out_src_r    <= grant_idx_s;
                        done0_r      <= 1'b0;
                        done1_r      <= 1'b0;
                        out0_valid_r <= 1'b1;
                        out1_valid_r <= 1'b1;
                        state_r      <= S_SEND;
                    end else begin
                        state_r      <= S_IDLE;
                    end
                end
                S_SEND: begin
                    done0_r      <= done0_nxt_s;
                    done1_r      <= done1_nxt_s;
                    out0_valid_r <= ~done0_nxt_s;
                    out1_valid_r <= ~done1_nxt_s;
                    if (both_done_s) begin
                        bcast_cnt_r <= bcast_cnt_r + 16'd1;
                        rr_ptr_r    <= src_inc_s;
                        gap_cnt_r   <= 4'(GAP_CYC);
                        state_r     <= END_STATE;
                    end else begin
                        state_r     <= S_SEND;
                    end
                end
`ifdef PE_BCAST_INIT_TOKEN_EN
                // Token delivery reuses the send handshake but leaves counters and pointer alone.
                S_INIT: begin
                    done0_r      <= done0_nxt_s;
                    done1_r      <= done1_nxt_s;
                    out0_valid_r <= ~done0_nxt_s;
                    out1_valid_r <= ~done1_nxt_s;
                    if (both_done_s) begin
                        gap_cnt_r <= 4'(GAP_CYC);
                        state_r   <= END_STATE;
                    end else begin
                        state_r   <= S_INIT;
                    end
                end
`endif
                S_GAP: begin
                    if (gap_cnt_r <= 4'd1) begin
                        gap_cnt_r <= 4'd0;
                        state_r   <= S_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                end
                default: begin
                    out0_valid_r <= 1'b0;
                    out1_valid_r <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_bcast_arbiter.sv
// Scoreboard bench for pe_bcast_arbiter: directed packets, expected grants/outputs queued, monitor compares.
module tb_pe_bcast_arbiter;
    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int GAP   = 3;

    typedef struct packed {
        logic [1:0] src;
        logic [3:0] data;
    } pkt_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [15:0]      req_data;
    logic             out0_valid, out0_ready, out1_valid, out1_ready;
    logic [3:0]       out0_data;
    logic [1:0]       out_src;
    logic             busy;
    logic [15:0]      bcast_cnt;

    int               n_chk = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               exp_cnt = 0;
    pkt_t             exp0_q[$];
    pkt_t             exp1_q[$];
    logic [3:0]       expg_q[$];
    logic [3:0]       dat [NREQ][16];
    int               head [NREQ];
    int               tail [NREQ];
    logic [3:0]       gnt_q = 4'd0;
    logic             r0_cmd = 1'b1;
    logic             r1_cmd = 1'b1;
    logic             chk_gap = 1'b0;
    logic             have_hs = 1'b0;
    int               last_hs = 0;

    pe_bcast_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out_src(out_src), .busy(busy), .bcast_cnt(bcast_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_req(input int i, input logic [3:0] d);
        dat[i][tail[i]] = d;
        tail[i]++;
    endtask

    task automatic expect_pkt(input int i, input logic [3:0] d);
        pkt_t p;
        p.src  = 2'(i);
        p.data = d;
        exp0_q.push_back(p);
        exp1_q.push_back(p);
        expg_q.push_back(4'b0001 << i);
        exp_cnt++;
    endtask

    task automatic drain(input int budget);
        int  n;
        logic idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            @(negedge clk);
            n++;
            idle = (exp0_q.size() == 0) && (exp1_q.size() == 0) && (expg_q.size() == 0)
                   && !busy && (req_valid == 4'd0);
        end
        if (!idle) chk("drain_timeout", 32'(n), 32'(budget + 1));
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!busy) chk("busy_timeout", 32'(busy), 32'd1);
    endtask

    task automatic post_reset();
`ifdef PE_BCAST_INIT_TOKEN_EN
        pkt_t p;
        p.src  = 2'd0;
        p.data = 4'd0;
        exp0_q.push_back(p);
        exp1_q.push_back(p);
        drain(50);
        chk("token_bcast_cnt", 32'(bcast_cnt), 32'd0);
`endif
    endtask

    // Requester model: retire a packet on a grant seen at the previous negedge, present the next.
    initial begin
        req_valid  = 4'd0;
        req_data   = 16'd0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_q[i] && head[i] != tail[i]) head[i]++;
                req_valid[i]         = (head[i] != tail[i]);
                req_data[i*4 +: 4]   = (head[i] != tail[i]) ? dat[i][head[i]] : 4'd0;
            end
            gnt_q      = 4'd0;
            out0_ready = r0_cmd;
            out1_ready = r1_cmd;
        end
    end

    // Monitor: compare grants and every output handshake against the scoreboard queues.
    always @(negedge clk) begin
        pkt_t e;
        logic hs;
        hs = 1'b0;
        if (rst_n) begin
            gnt_q = req_ready;
            if (req_ready != 4'd0) begin
                if (expg_q.size() == 0) chk("grant_unexpected", 32'(req_ready), 32'd0);
                else chk("grant", 32'(req_ready), 32'(expg_q.pop_front()));
                if (chk_gap && have_hs) chk("gap_idle_cycles", 32'(cyc - last_hs - 1), 32'(GAP));
            end
            if (out0_valid && out0_ready) begin
                hs = 1'b1;
                if (exp0_q.size() == 0) chk("out0_unexpected", 32'({out_src, out0_data}), 32'hFFFF);
                else begin
                    e = exp0_q.pop_front();
                    chk("out0_data", 32'(out0_data), 32'(e.data));
                    chk("out0_src", 32'(out_src), 32'(e.src));
                end
            end
            if (out1_valid && out1_ready) begin
                hs = 1'b1;
                if (exp1_q.size() == 0) chk("out1_unexpected", 32'({out_src, out0_data}), 32'hFFFF);
                else begin
                    e = exp1_q.pop_front();
                    chk("out1_data", 32'(out0_data), 32'(e.data));
                    chk("out1_src", 32'(out_src), 32'(e.src));
                end
            end
            if (hs) begin
                last_hs = cyc;
                have_hs = 1'b1;
            end
        end else begin
            gnt_q = 4'd0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("rst_out0_data", 32'(out0_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_bcast_cnt", 32'(bcast_cnt), 32'd0);
`ifndef PE_BCAST_INIT_TOKEN_EN
        chk("rst_busy", 32'(busy), 32'd0);
`endif
        rst_n = 1'b1;
        post_reset();

        // All four requesters hold two packets each: strict rotation and exact gap spacing.
        chk_gap = 1'b1;
        have_hs = 1'b0;
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < NREQ; i++) begin
                add_req(i, 4'(i * 4 + n + 1));
                expect_pkt(i, 4'(i * 4 + n + 1));
            end
        drain(200);
        chk_gap = 1'b0;
        chk("t2_bcast_cnt", 32'(bcast_cnt), 32'(exp_cnt));

        // Single requester 2, data 0xA.
        add_req(2, 4'hA);
        expect_pkt(2, 4'hA);
        drain(50);
        chk("t1_bcast_cnt", 32'(bcast_cnt), 32'(exp_cnt));

        // Consumer 1 stalls five cycles: out1 holds its packet, no new grant meanwhile.
        r1_cmd = 1'b0;
        add_req(1, 4'h7);
        expect_pkt(1, 4'h7);
        wait_busy(20);
        add_req(3, 4'h3);
        expect_pkt(3, 4'h3);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk("t3_out0_valid_low", 32'(out0_valid), 32'd0);
            end
            chk("t3_out1_valid", 32'(out1_valid), 32'd1);
            chk("t3_data_hold", 32'(out0_data), 32'h7);
            chk("t3_src_hold", 32'(out_src), 32'd1);
            chk("t3_no_grant", 32'(req_ready), 32'd0);
        end
        r1_cmd = 1'b1;
        drain(50);
        chk("t3_bcast_cnt", 32'(bcast_cnt), 32'(exp_cnt));

        // Move rr_ptr off zero, then reset in the middle of a send.
        add_req(1, 4'h9);
        expect_pkt(1, 4'h9);
        drain(50);
        r0_cmd = 1'b0;
        r1_cmd = 1'b0;
        add_req(2, 4'hC);
        expg_q.push_back(4'b0100);
        wait_busy(20);
        chk("t5_valid_before_rst", 32'(out0_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_out0_valid", 32'(out0_valid), 32'd0);
        chk("t5_async_out1_valid", 32'(out1_valid), 32'd0);
        chk("t5_async_bcast_cnt", 32'(bcast_cnt), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        r0_cmd  = 1'b1;
        r1_cmd  = 1'b1;
        post_reset();
        add_req(1, 4'h6);
        add_req(3, 4'hE);
        expect_pkt(1, 4'h6);
        expect_pkt(3, 4'hE);
        drain(80);
        chk("t5_bcast_cnt", 32'(bcast_cnt), 32'(exp_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
